// File: rtl/dmem_if.sv
// Core-to-memory dmem_* load/store bus; the core is the master, dmem_ctrl the slave.
interface dmem_if;
  logic        dmem_ena;
  logic        dmem_w;
  logic        dmem_r;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_data_to_write;
  logic        issw;
  logic        islw;
  logic        issb;
  logic        issh;
  logic        islb;
  logic        islh;
  logic        islbu;
  logic        islhu;
  logic [31:0] dmem_data;
  logic        ready;
  logic        busy;
  logic        addr_err;

  modport master (
    output dmem_ena, dmem_w, dmem_r, dmem_addr, dmem_data_to_write,
           issw, islw, issb, issh, islb, islh, islbu, islhu,
    input  dmem_data, ready, busy, addr_err
  );

  modport slave (
    input  dmem_ena, dmem_w, dmem_r, dmem_addr, dmem_data_to_write,
           issw, islw, issb, issh, islb, islh, islbu, islhu,
    output dmem_data, ready, busy, addr_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory responder: word RAM serving lw/sw/lb/lbu/lh/lhu/sb/sh,
// sub-word stores by read-modify-write, one-cycle ready pulse per request.
module dmem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ena,
  dmem_if.slave  bus
);

  localparam int unsigned AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP, ERR} state_t;
  typedef enum logic [2:0] {OP_LW, OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SB, OP_SH} op_t;

  state_t        state, state_nxt;
  op_t           op_in, op_q;
  logic [31:0]   off;
  logic [7:0]    flags;
  logic          req_err;
  logic [1:0]    lane_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rd_word;
  logic [31:0]   merged;
  logic [31:0]   dmem_data_q;
  logic          is_load_q;
  logic          unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  assign off         = bus.dmem_addr - BASE_ADDR;
  assign flags       = {bus.issw, bus.islw, bus.issb, bus.issh,
                        bus.islb, bus.islh, bus.islbu, bus.islhu};
  assign is_load_q   = !(op_q inside {OP_SW, OP_SB, OP_SH});
  assign unused_bits = bus.dmem_w ^ bus.dmem_r;

  function automatic logic [31:0] load_ext(op_t op, logic [1:0] lane, logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (op)
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h0, b};
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0, h};
      default: load_ext = w;
    endcase
  endfunction

  // Decode the incoming request type and check range, alignment and flag count.
  always_comb begin
    op_in = OP_LW;
    if      (bus.issw)  op_in = OP_SW;
    else if (bus.issb)  op_in = OP_SB;
    else if (bus.issh)  op_in = OP_SH;
    else if (bus.islb)  op_in = OP_LB;
    else if (bus.islbu) op_in = OP_LBU;
    else if (bus.islh)  op_in = OP_LH;
    else if (bus.islhu) op_in = OP_LHU;
    req_err = (bus.dmem_addr < BASE_ADDR) || (off >= SPAN) || ($countones(flags) != 1);
    if ((bus.issw || bus.islw) && bus.dmem_addr[1:0] != 2'b00)
      req_err = 1'b1;
    if ((bus.issh || bus.islh || bus.islhu) && bus.dmem_addr[0])
      req_err = 1'b1;
  end

  // State register; reset wins over ena, ena=0 freezes.
  always_ff @(posedge clk) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.dmem_ena) begin
               if (req_err)             state_nxt = ERR;
               else if (op_in == OP_SW) state_nxt = WRITE;
               else                     state_nxt = READ;
             end
      READ:  state_nxt = is_load_q ? RESP : MERGE;
      MERGE: state_nxt = RESP;
      WRITE: state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    bus.busy     = (state != IDLE);
    bus.ready    = (state == RESP) || (state == ERR);
    bus.addr_err = (state == ERR);
    bus.dmem_data = dmem_data_q;
  end

  // Latch the request at acceptance.
  always_ff @(posedge clk) begin
    if (ena && state == IDLE && bus.dmem_ena) begin
      op_q    <= op_in;
      lane_q  <= bus.dmem_addr[1:0];
      widx_q  <= off[AW+1:2];
      wdata_q <= bus.dmem_data_to_write;
    end
  end

  // Insert the store byte/halfword into the word read back from RAM.
  always_comb begin
    merged = rd_word;
    if (op_q == OP_SB) merged[{lane_q, 3'b000} +: 8]   = wdata_q[7:0];
    else               merged[{lane_q[1], 4'h0} +: 16] = wdata_q[15:0];
  end

  // RAM port: writes are gated by rst_n so a reset edge never commits a store.
  always_ff @(posedge clk) begin
    if (ena && rst_n) begin
      if (state == WRITE)      mem[widx_q] <= wdata_q;
      else if (state == MERGE) mem[widx_q] <= merged;
    end
    if (ena && state == READ) rd_word <= mem[widx_q];
  end

  // Load result register: captured on the READ edge so it is valid with ready.
  always_ff @(posedge clk) begin
    if (!rst_n)
      dmem_data_q <= '0;
    else if (ena && state == READ && is_load_q)
      dmem_data_q <= load_ext(op_q, lane_q, mem[widx_q]);
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table, hand-written corner
// sequences (abort, freeze) and randomized requests against a word-array model.
module tb_dmem_ctrl;

  localparam int unsigned DEPTH = 2048;
  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          SPAN  = DEPTH * 4;

  localparam logic [7:0] F_SW = 8'h80, F_LW = 8'h40, F_SB = 8'h20, F_SH = 8'h10,
                         F_LB = 8'h08, F_LH = 8'h04, F_LBU = 8'h02, F_LHU = 8'h01,
                         F_NONE = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  dmem_if bus ();

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_mem [int];
  logic [31:0] m_data;

  typedef struct {
    logic [7:0]  flags;
    int          off;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] flags, input int off, input logic [31:0] wd);
    bus.dmem_ena           = 1'b1;
    bus.dmem_addr          = BASE + 32'(off);
    bus.dmem_data_to_write = wd;
    {bus.issw, bus.islw, bus.issb, bus.issh, bus.islb, bus.islh, bus.islbu, bus.islhu} = flags;
    bus.dmem_w = |(flags & (F_SW | F_SB | F_SH));
    bus.dmem_r = |(flags & (F_LW | F_LB | F_LH | F_LBU | F_LHU));
  endtask

  // One request from IDLE; latency counted in edges from acceptance to ready.
  task automatic do_req(input logic [7:0] flags, input int off, input logic [31:0] wd,
                        output logic [31:0] data, output logic err, output int lat);
    @(negedge clk);
    drive(flags, off, wd);
    @(posedge clk); #1;
    lat = 1;
    while (!bus.ready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus.dmem_data;
    err  = bus.addr_err;
    bus.dmem_ena = 1'b0;
    @(posedge clk);
  endtask

  // Behavioural model: memory as a word array, loads by shift/mask arithmetic.
  task automatic model_req(input logic [7:0] flags, input int off, input logic [31:0] wd,
                           output logic exp_err, output int exp_lat);
    int w, lane, b, h;
    logic [31:0] word;
    bit half;
    w    = (off >= 0) ? off / 4 : -1;
    lane = (off >= 0) ? off % 4 : 0;
    half = (flags == F_SH) || (flags == F_LH) || (flags == F_LHU);
    exp_err = (off < 0) || (off >= SPAN) || ($countones(flags) != 1) ||
              ((flags == F_SW || flags == F_LW) && lane != 0) || (half && lane % 2 != 0);
    if (exp_err) begin
      exp_lat = 1;
      return;
    end
    word = m_mem.exists(w) ? m_mem[w] : 32'h0;
    b = int'((word >> (8 * lane)) & 32'hFF);
    h = int'((word >> (8 * lane)) & 32'hFFFF);
    exp_lat = 2;
    case (flags)
      F_SW:  m_mem[w] = wd;
      F_LW:  m_data = word;
      F_LB:  m_data = 32'((b > 127) ? b - 256 : b);
      F_LBU: m_data = 32'(b);
      F_LH:  m_data = 32'((h > 32767) ? h - 65536 : h);
      F_LHU: m_data = 32'(h);
      F_SB: begin
        m_mem[w] = (word & ~(32'hFF << (8 * lane))) | ((wd & 32'hFF) << (8 * lane));
        exp_lat = 3;
      end
      default: begin
        m_mem[w] = (word & ~(32'hFFFF << (8 * lane))) | ((wd & 32'hFFFF) << (8 * lane));
        exp_lat = 3;
      end
    endcase
  endtask

  initial begin
    logic [31:0] d;
    logic        e, me;
    int          l, ml;

    vecs = '{
      '{F_SW,  8,        32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2},
      '{F_LW,  8,        32'h0,         32'hDEAD_BEEF, 1'b0, 2},
      '{F_SW,  0,        32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2},
      '{F_SB,  1,        32'hFFFF_FF85, 32'hDEAD_BEEF, 1'b0, 3},
      '{F_LW,  0,        32'h0,         32'h0000_8500, 1'b0, 2},
      '{F_LB,  1,        32'h0,         32'hFFFF_FF85, 1'b0, 2},
      '{F_LBU, 1,        32'h0,         32'h0000_0085, 1'b0, 2},
      '{F_SW,  4,        32'h1111_1111, 32'h0000_0085, 1'b0, 2},
      '{F_SH,  6,        32'hABCD_8001, 32'h0000_0085, 1'b0, 3},
      '{F_LW,  4,        32'h0,         32'h8001_1111, 1'b0, 2},
      '{F_LH,  6,        32'h0,         32'hFFFF_8001, 1'b0, 2},
      '{F_LHU, 6,        32'h0,         32'h0000_8001, 1'b0, 2},
      '{F_LW,  2,        32'h0,         32'h0000_8001, 1'b1, 1},
      '{F_SH,  3,        32'h5555_5555, 32'h0000_8001, 1'b1, 1},
      '{F_SW,  -4,       32'h5555_5555, 32'h0000_8001, 1'b1, 1},
      '{F_SW | F_LW, 0,  32'h5555_5555, 32'h0000_8001, 1'b1, 1},
      '{F_NONE, 0,       32'h5555_5555, 32'h0000_8001, 1'b1, 1},
      '{F_SW,  SPAN,     32'h5555_5555, 32'h0000_8001, 1'b1, 1},
      '{F_SW,  SPAN - 4, 32'h1234_5678, 32'h0000_8001, 1'b0, 2},
      '{F_LW,  SPAN - 4, 32'h0,         32'h1234_5678, 1'b0, 2},
      '{F_LW,  0,        32'h0,         32'h0000_8500, 1'b0, 2},
      '{F_LB,  7,        32'h0,         32'hFFFF_FF80, 1'b0, 2},
      '{F_LHU, 4,        32'h0,         32'h0000_1111, 1'b0, 2},
      '{F_LB,  0,        32'h0,         32'h0000_0000, 1'b0, 2},
      '{F_LBU, 5,        32'h0,         32'h0000_0011, 1'b0, 2},
      '{F_SB,  7,        32'h0000_007F, 32'h0000_0011, 1'b0, 3},
      '{F_LW,  4,        32'h0,         32'h7F01_1111, 1'b0, 2}
    };

    rst_n = 1'b0;
    ena   = 1'b1;
    drive(F_NONE, 0, 32'h0);
    bus.dmem_ena = 1'b0;
    m_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'h0, bus.ready}, 32'h0);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_addr_err", {31'h0, bus.addr_err}, 32'h0);
    chk("reset_dmem_data", bus.dmem_data, 32'h0);
    rst_n = 1'b1;

    // directed table
    foreach (vecs[i]) begin
      do_req(vecs[i].flags, vecs[i].off, vecs[i].wdata, d, e, l);
      model_req(vecs[i].flags, vecs[i].off, vecs[i].wdata, me, ml);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(l), 32'(vecs[i].exp_lat));
    end

    // abort: reset during the READ cycle of sb @+0
    @(negedge clk);
    drive(F_SB, 0, 32'h0000_00AA);
    @(posedge clk); #1;
    chk("abort_busy_in_read", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", {31'h0, bus.ready}, 32'h0);
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_addr_err", {31'h0, bus.addr_err}, 32'h0);
    chk("abort_dmem_data", bus.dmem_data, 32'h0);
    rst_n = 1'b1;
    bus.dmem_ena = 1'b0;
    m_data = 32'h0;
    do_req(F_LW, 0, 32'h0, d, e, l);
    model_req(F_LW, 0, 32'h0, me, ml);
    chk("abort_word_kept", d, 32'h0000_8500);

    // freeze: ena low for 3 cycles during an lw READ, then during RESP
    @(negedge clk);
    drive(F_LW, 8, 32'h0);
    @(posedge clk); #1;
    ena = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("freeze_ready_%0d", k), {31'h0, bus.ready}, 32'h0);
      chk($sformatf("freeze_busy_%0d", k), {31'h0, bus.busy}, 32'h1);
    end
    ena = 1'b1;
    @(posedge clk); #1;
    chk("freeze_ready_after", {31'h0, bus.ready}, 32'h1);
    chk("freeze_data", bus.dmem_data, 32'hDEAD_BEEF);
    ena = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stretch_ready_%0d", k), {31'h0, bus.ready}, 32'h1);
    end
    ena = 1'b1;
    bus.dmem_ena = 1'b0;
    @(posedge clk); #1;
    chk("stretch_end_ready", {31'h0, bus.ready}, 32'h0);
    chk("stretch_end_busy", {31'h0, bus.busy}, 32'h0);
    model_req(F_LW, 8, 32'h0, me, ml);

    // randomized: initialise words 0..15, then mixed requests
    for (int w = 0; w < 16; w++) begin
      logic [31:0] r;
      r = $urandom;
      do_req(F_SW, w * 4, r, d, e, l);
      model_req(F_SW, w * 4, r, me, ml);
    end
    for (int n = 0; n < 200; n++) begin
      logic [7:0]  fl;
      logic [31:0] wd;
      int          sel, off;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)       fl = 8'(1 << sel);
      else if (sel == 8) fl = 8'((1 << $urandom_range(0, 3)) | (1 << $urandom_range(4, 7)));
      else               fl = F_NONE;
      case ($urandom_range(0, 9))
        0:       off = -int'($urandom_range(1, 8));
        1:       off = SPAN + int'($urandom_range(0, 7));
        default: off = int'($urandom_range(0, 63));
      endcase
      wd = $urandom;
      do_req(fl, off, wd, d, e, l);
      model_req(fl, off, wd, me, ml);
      chk($sformatf("rnd%0d_data", n), d, m_data);
      chk($sformatf("rnd%0d_err", n), {31'h0, e}, {31'h0, me});
      chk($sformatf("rnd%0d_latency", n), 32'(l), 32'(ml));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder for the MIPS core: the memory-side end of the core's `dmem_*` load/store interface. It owns a word-wide synchronous RAM and serves lw/sw/lb/lbu/lh/lhu/sb/sh requests. Sub-word stores are done as read-modify-write, and loads are sign- or zero-extended. A `ready` pulse tells the core's stall logic when a request has retired.

## Interface
Parameters:
- `DEPTH_WORDS`, 2048: RAM depth in 32-bit words; must be a power of two.
- `BASE_ADDR`, 32'h1001_0000: byte address of word 0.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset; synchronous, active-low.
- `ena`  in  1: global enable. When low, the FSM, outputs and RAM are frozen.
- `dmem_ena`  in  1: request valid.
- `dmem_w`, `dmem_r`  in  1 each: informational only. The type flags decide the operation.
- `dmem_addr`  in  32: byte address.
- `dmem_data_to_write`  in  32: store data; sb/sh use the low byte or halfword.
- `issw`, `islw`, `issb`, `issh`, `islb`, `islh`, `islbu`, `islhu`  in  1 each: one-hot operation type.
- `dmem_data`  out  32: load result.
- `ready`  out  1: one-cycle pulse marking retirement.
- `busy`  out  1: high in every non-IDLE state.
- `addr_err`  out  1: one-cycle pulse, coincident with `ready`, for a rejected request.

## Operation
- Byte order is little-endian: `addr[1:0]`=0 selects bits 7:0.
- Word index is `(dmem_addr - BASE_ADDR) >> 2`.
- Out of range means the offset is ≥ `DEPTH_WORDS*4`, or `dmem_addr` < `BASE_ADDR`.
- A request is rejected (error) when any of these holds:
  - it is out of range;
  - it is misaligned: lw/sw with `addr[1:0]`≠0, or lh/lhu/sh with `addr[0]`≠0;
  - the number of type flags set is not exactly one.
- A rejected request performs no RAM access. `dmem_data` is unchanged.
- FSM states:
  - IDLE: a request is accepted on a rising edge with `ena`=1 and `dmem_ena`=1. Inputs are latched at acceptance. Next state:
    - error → ERR;
    - sw → WRITE;
    - any load, sb or sh → READ.
  - READ: RAM read issued; data is available in the next state. Next state: loads → RESP; sb/sh → MERGE.
  - MERGE: substitutes the new byte or halfword into the read word at the lane given by `addr[1:0]`, writes the RAM, then → RESP.
  - WRITE: writes the full word, then → RESP.
  - RESP: `ready`=1. For a load, `dmem_data` is registered with the extended value:
    - lb/lh sign-extend bit 7/15;
    - lbu/lhu zero-extend;
    - lw takes the whole word.
    Then → IDLE.
  - ERR: `ready`=1 and `addr_err`=1, then → IDLE.
- The core holds the request stable until `ready`. `dmem_ena` seen while busy is ignored; there is no queuing.
- `dmem_data` holds the last load result until the next load completes. Stores never modify it.
- RAM contents are not reset or initialised.

## Timing
- Reset values: state IDLE, `dmem_data`=0, `ready`=0, `busy`=0, `addr_err`=0.
- Reset overrides `ena`.
- Latency from the acceptance edge to the `ready`-high cycle:
  - error: 1 cycle;
  - sw: 2 cycles;
  - load: 2 cycles;
  - sb/sh: 3 cycles.
- Earliest new acceptance is the edge after the `ready` cycle, i.e. the FSM returns to IDLE for one cycle.
- `ena`=0 in any state: no transition, no RAM write, and all outputs hold. A `ready` pulse stretches until the first enabled edge.
- Reset asserted in READ or MERGE aborts the request. A RAM write scheduled for the reset edge is suppressed, so memory keeps its old value.
- Write-then-read to the same word on back-to-back requests returns the new data; no bypass is needed because the FSM serialises requests.

## Test plan
- sw 32'hDEAD_BEEF @ `BASE_ADDR`+8, then lw @ +8 → `dmem_data`=32'hDEAD_BEEF. `ready` comes 2 cycles after each acceptance, and `addr_err`=0.
- Byte lanes, starting from word 0 = 32'h0000_0000:
  - sb 8'h85 @ +1 → word becomes 32'h0000_8500;
  - lb @ +1 → 32'hFFFF_FF85;
  - lbu @ +1 → 32'h0000_0085;
  - `ready` for the sb arrives 3 cycles after acceptance.
- Halfword: sh 16'h8001 @ +6 over a word of 32'h1111_1111 → word 32'h8001_1111. Then lh @ +6 → 32'hFFFF_8001, and lhu @ +6 → 32'h0000_8001.
- Errors, each giving `ready`=`addr_err`=1 one cycle after acceptance with memory and `dmem_data` unchanged:
  - lw @ +2;
  - sh @ +3;
  - sw @ `BASE_ADDR`−4;
  - sw with `issw`=`islw`=1.
- Abort: rst_n low in the READ cycle of sb @ +0 → FSM in IDLE with all outputs 0 next cycle. A following lw @ +0 returns the original word.
- Freeze: `ena`=0 for 3 cycles during an lw READ → no progress while low. `ready` appears 1 cycle after `ena` returns, with correct data.
